// File: rtl/lp805x_prng.sv
// Galois LFSR random-number generator with request/valid draw handshake,
// free-run mode, optional entropy injection and zero-lock protection.
module lp805x_prng #(
  parameter int              WIDTH      = 32,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(32'h00000001),
  parameter int              OUT_W      = 8,
  parameter int              STEPS      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loadseed_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             mode_i,
  input  logic             req_i,
  input  logic             entropy_en_i,
  input  logic             entropy_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [OUT_W-1:0] number_o,
  output logic [WIDTH-1:0] state_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             draw_fr, draw_fr_nxt;
  logic             step_en, accept;
  logic [WIDTH-1:0] state_p0, state_nxt;
  logic [OUT_W-1:0] sample_p0;
  logic [OUT_W-1:0] number_p1;
  logic             vld_p1;

  // One Galois step; an all-zero result would lock the LFSR forever.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                 input logic en,
                                                 input logic bit_in);
    logic [WIDTH-1:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ POLY;
    if (en) n[WIDTH-1] = n[WIDTH-1] ^ bit_in;
    if (n == '0) n = RESET_SEED;
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
    return (s == '0) ? RESET_SEED : s;
  endfunction

  always_comb begin
    fsm_nxt     = fsm;
    cnt_nxt     = cnt;
    draw_fr_nxt = draw_fr;
    step_en     = 1'b0;
    accept      = 1'b0;
    case (fsm)
      IDLE: begin
        step_en = mode_i;
        if (req_i && !loadseed_i) begin
          accept      = 1'b1;
          draw_fr_nxt = mode_i;
          if (mode_i) begin
            fsm_nxt = DONE;
          end else begin
            fsm_nxt = RUN;
            cnt_nxt = 8'(STEPS - 1);
          end
        end
      end
      RUN: begin
        step_en = 1'b1;
        if (loadseed_i) begin
          fsm_nxt = IDLE;
          cnt_nxt = '0;
        end else if (cnt == '0) begin
          fsm_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DONE: begin
        step_en = draw_fr;
        fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase

    if (loadseed_i)   state_nxt = seed_fix(seed_i);
    else if (step_en) state_nxt = lfsr_step(state_p0, entropy_en_i, entropy_i);
    else              state_nxt = state_p0;
  end

  // p0: LFSR state and draw control
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm      <= IDLE;
      cnt      <= '0;
      draw_fr  <= 1'b0;
      state_p0 <= RESET_SEED;
    end else begin
      fsm      <= fsm_nxt;
      cnt      <= cnt_nxt;
      draw_fr  <= draw_fr_nxt;
      state_p0 <= state_nxt;
    end
  end

  // Free-run draws report the state seen at the request edge.
  always_ff @(posedge clk) begin
    if (accept) sample_p0 <= state_p0[OUT_W-1:0];
  end

  // p1: published number and valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      number_p1 <= '0;
    end else begin
      vld_p1 <= (fsm == DONE);
      if (fsm == DONE) number_p1 <= draw_fr ? sample_p0 : state_p0[OUT_W-1:0];
    end
  end

  assign busy_o   = (fsm == RUN) || ((fsm == DONE) && draw_fr);
  assign valid_o  = vld_p1;
  assign number_o = number_p1;
  assign state_o  = state_p0;

endmodule
